// File: rtl/memory_request_arbiter_pkg.sv
// Shared types for the memory request arbiter:
// requester identity, FSM states and access sizes.
package memory_arbiter_params;

  typedef enum logic {
    SOURCE_INST = 1'b0,
    SOURCE_DATA = 1'b1
  } source_t;

  typedef enum logic [1:0] {
    ARBITER_IDLE      = 2'd0,
    ARBITER_HOLD_INST = 2'd1,
    ARBITER_HOLD_DATA = 2'd2
  } arbiter_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/memory_request_arbiter_if.sv
// SRAM-like channel: request/address_ok for issue,
// data_ok/read_data for the in-order response.
interface memory_request_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);

  logic                     request;
  logic                     write;
  logic [1:0]               size;
  logic [3:0]               write_strobe;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0]    write_data;
  logic                     address_ok;
  logic [DATA_WIDTH-1:0]    read_data;
  logic                     data_ok;

  modport master (
    output request, write, size, write_strobe,
    output address, write_data,
    input  address_ok, read_data, data_ok
  );

  modport slave (
    input  request, write, size, write_strobe,
    input  address, write_data,
    output address_ok, read_data, data_ok
  );

endinterface

// File: rtl/memory_request_arbiter_fifo.sv
// Order FIFO: one source bit per outstanding
// transaction, popped as responses return.
module request_order_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     push_data,
  input  logic                     pop,
  output logic                     head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] slots;
  logic [PW-1:0]    write_pointer;
  logic [PW-1:0]    read_pointer;

  assign head  = slots[read_pointer];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Payload storage; contents are don't-care when empty.
  always_ff @(posedge clock) begin
    if (push) slots[write_pointer] <= push_data;
  end

  // Pointers wrap naturally; count tracks push minus pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      write_pointer <= '0;
      read_pointer  <= '0;
      count         <= '0;
    end else begin
      if (push) write_pointer <= write_pointer + 1'b1;
      if (pop)  read_pointer  <= read_pointer + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/memory_request_arbiter.sv
// Arbitrates fetch and io-stage requests onto one
// memory port and routes responses back in order.
module memory_request_arbiter
  import memory_arbiter_params::*;
#(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 4
) (
  input logic                      clock,
  input logic                      reset,
  memory_request_arbiter_if.slave  inst,
  memory_request_arbiter_if.slave  data,
  memory_request_arbiter_if.master bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  arbiter_state_t state;
  arbiter_state_t state_next;
  source_t        grant;
  logic           grant_valid;
  logic [SW-1:0]  starve_count;
  logic           starved;

  logic           accept;
  logic           pop;
  logic           fifo_head;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;

  assign starved = inst.request &&
                   (starve_count == SW'(STARVE_LIMIT));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= ARBITER_IDLE;
    else       state <= state_next;
  end

  // Grant selection and next state; HOLD locks the source.
  always_comb begin
    state_next  = state;
    grant       = SOURCE_DATA;
    grant_valid = 1'b0;
    unique case (state)
      ARBITER_IDLE: begin
        if (!fifo_full && (inst.request || data.request)) begin
          grant_valid = 1'b1;
          grant = (data.request && !starved) ?
                  SOURCE_DATA : SOURCE_INST;
          if (!bus.address_ok)
            state_next = (grant == SOURCE_INST) ?
                         ARBITER_HOLD_INST : ARBITER_HOLD_DATA;
        end
      end
      ARBITER_HOLD_INST: begin
        grant_valid = 1'b1;
        grant       = SOURCE_INST;
        if (bus.address_ok) state_next = ARBITER_IDLE;
      end
      ARBITER_HOLD_DATA: begin
        grant_valid = 1'b1;
        grant       = SOURCE_DATA;
        if (bus.address_ok) state_next = ARBITER_IDLE;
      end
      default: state_next = ARBITER_IDLE;
    endcase
    if (reset) begin
      grant_valid = 1'b0;
      state_next  = ARBITER_IDLE;
    end
  end

  // Forward the granted requester onto the memory port.
  always_comb begin
    bus.request      = 1'b0;
    bus.write        = 1'b0;
    bus.size         = 2'd0;
    bus.write_strobe = 4'd0;
    bus.address      = '0;
    bus.write_data   = '0;
    if (grant_valid) begin
      if (grant == SOURCE_DATA) begin
        bus.request      = data.request;
        bus.write        = data.write;
        bus.size         = data.size;
        bus.write_strobe = data.write_strobe;
        bus.address      = data.address;
        bus.write_data   = data.write_data;
      end else begin
        bus.request      = inst.request;
        bus.size         = SIZE_WORD;
        bus.address      = inst.address;
      end
    end
  end

  assign accept = bus.request && bus.address_ok;
  assign pop    = bus.data_ok && !fifo_empty && !reset;

  assign inst.address_ok = accept && (grant == SOURCE_INST);
  assign data.address_ok = accept && (grant == SOURCE_DATA);

  assign inst.data_ok   = pop && (source_t'(fifo_head) == SOURCE_INST);
  assign data.data_ok   = pop && (source_t'(fifo_head) == SOURCE_DATA);
  assign inst.read_data = bus.read_data;
  assign data.read_data = bus.read_data;

  // Counts data wins while fetch waits; fetch wins at the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_count <= '0;
    end else if (!inst.request || inst.address_ok) begin
      starve_count <= '0;
    end else if (data.address_ok &&
                 starve_count != SW'(STARVE_LIMIT)) begin
      starve_count <= starve_count + 1'b1;
    end
  end

  // A response with nothing outstanding is a memory-side bug.
  always_ff @(posedge clock) begin
    if (!reset && bus.data_ok)
      assert (!fifo_empty);
  end

  request_order_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data (grant == SOURCE_DATA),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_memory_request_arbiter.sv
// Directed bench for memory_request_arbiter:
// arbitration, hold, ordering, full and reset.
module tb_memory_request_arbiter;
  import memory_arbiter_params::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  memory_request_arbiter_if inst_if ();
  memory_request_arbiter_if data_if ();
  memory_request_arbiter_if bus_if ();

  memory_request_arbiter dut (
    .clock (clock),
    .reset (reset),
    .inst  (inst_if),
    .data  (data_if),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet();
    inst_if.request      = 1'b0;
    inst_if.write        = 1'b0;
    inst_if.size         = 2'd0;
    inst_if.write_strobe = 4'd0;
    inst_if.address      = '0;
    inst_if.write_data   = '0;
    data_if.request      = 1'b0;
    data_if.write        = 1'b0;
    data_if.size         = 2'd0;
    data_if.write_strobe = 4'd0;
    data_if.address      = '0;
    data_if.write_data   = '0;
    bus_if.address_ok    = 1'b0;
    bus_if.read_data     = '0;
    bus_if.data_ok       = 1'b0;
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_bus_req"}, bus_if.request, 0);
    check({tag, "_bus_addr"}, bus_if.address, 0);
    check({tag, "_i_aok"}, inst_if.address_ok, 0);
    check({tag, "_d_aok"}, data_if.address_ok, 0);
    check({tag, "_i_dok"}, inst_if.data_ok, 0);
    check({tag, "_d_dok"}, data_if.data_ok, 0);
    check({tag, "_count"}, dut.u_fifo.count, 0);
    check({tag, "_state"}, dut.state, ARBITER_IDLE);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    quiet();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    settle();
    outputs_zero("reset");

    // Starvation guard: four data wins, then fetch.
    inst_if.request   = 1'b1;
    inst_if.address   = 32'h0000_1000;
    data_if.request   = 1'b1;
    data_if.address   = 32'h0000_2000;
    bus_if.address_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_if.data_ok   = (i != 0);
      bus_if.read_data = 32'h100 + i;
      settle();
      check("starve_d_aok", data_if.address_ok, 1);
      check("starve_i_aok", inst_if.address_ok, 0);
      check("starve_addr", bus_if.address, 32'h2000);
      check("starve_d_dok", data_if.data_ok, (i != 0));
      tick();
    end
    bus_if.data_ok = 1'b1;
    settle();
    check("starve5_i_aok", inst_if.address_ok, 1);
    check("starve5_d_aok", data_if.address_ok, 0);
    check("starve5_addr", bus_if.address, 32'h1000);
    check("starve5_size", bus_if.size, SIZE_WORD);
    check("starve5_d_dok", data_if.data_ok, 1);
    tick();
    inst_if.request   = 1'b0;
    data_if.request   = 1'b0;
    bus_if.address_ok = 1'b0;
    bus_if.read_data  = 32'h5555;
    settle();
    check("starve_drain_i_dok", inst_if.data_ok, 1);
    check("starve_drain_rd", inst_if.read_data, 32'h5555);
    tick();
    quiet();
    settle();
    check("starve_empty", dut.u_fifo.count, 0);

    // Hold: data locked while address_ok stays low.
    data_if.request      = 1'b1;
    data_if.write        = 1'b1;
    data_if.size         = SIZE_HALF;
    data_if.write_strobe = 4'b0011;
    data_if.address      = 32'h0000_3002;
    data_if.write_data   = 32'hBEEF;
    inst_if.address      = 32'h0000_4000;
    settle();
    check("hold0_req", bus_if.request, 1);
    check("hold0_d_aok", data_if.address_ok, 0);
    tick();
    check("hold0_state", dut.state, ARBITER_HOLD_DATA);
    inst_if.request = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("hold_addr", bus_if.address, 32'h3002);
      check("hold_i_aok", inst_if.address_ok, 0);
      tick();
    end
    bus_if.address_ok = 1'b1;
    settle();
    check("hold3_d_aok", data_if.address_ok, 1);
    check("hold3_i_aok", inst_if.address_ok, 0);
    check("hold3_write", bus_if.write, 1);
    check("hold3_strobe", bus_if.write_strobe, 4'b0011);
    check("hold3_wdata", bus_if.write_data, 32'hBEEF);
    check("hold3_size", bus_if.size, SIZE_HALF);
    tick();
    data_if.request = 1'b0;
    settle();
    check("hold4_i_aok", inst_if.address_ok, 1);
    check("hold4_addr", bus_if.address, 32'h4000);
    check("hold4_write", bus_if.write, 0);
    check("hold4_strobe", bus_if.write_strobe, 0);
    tick();
    quiet();
    bus_if.data_ok = 1'b1;
    settle();
    check("hold_resp1_d", data_if.data_ok, 1);
    check("hold_resp1_i", inst_if.data_ok, 0);
    tick();
    settle();
    check("hold_resp2_i", inst_if.data_ok, 1);
    check("hold_resp2_d", data_if.data_ok, 0);
    tick();
    quiet();

    // Ordering: inst A, data B, inst C.
    bus_if.address_ok = 1'b1;
    inst_if.request   = 1'b1;
    inst_if.address   = 32'hA;
    tick();
    inst_if.request = 1'b0;
    data_if.request = 1'b1;
    data_if.address = 32'hB;
    tick();
    data_if.request = 1'b0;
    inst_if.request = 1'b1;
    inst_if.address = 32'hC;
    tick();
    quiet();
    settle();
    check("order_count", dut.u_fifo.count, 3);
    bus_if.data_ok   = 1'b1;
    bus_if.read_data = 32'h11;
    settle();
    check("order1_i_dok", inst_if.data_ok, 1);
    check("order1_d_dok", data_if.data_ok, 0);
    check("order1_rd", inst_if.read_data, 32'h11);
    tick();
    bus_if.read_data = 32'h22;
    settle();
    check("order2_i_dok", inst_if.data_ok, 0);
    check("order2_d_dok", data_if.data_ok, 1);
    check("order2_rd", data_if.read_data, 32'h22);
    tick();
    bus_if.read_data = 32'h33;
    settle();
    check("order3_i_dok", inst_if.data_ok, 1);
    check("order3_d_dok", data_if.data_ok, 0);
    tick();
    quiet();
    settle();
    check("order_empty", dut.u_fifo.count, 0);

    // Full FIFO blocks issue; a same-cycle pop does not.
    data_if.request   = 1'b1;
    data_if.address   = 32'h5000;
    bus_if.address_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("fill_d_aok", data_if.address_ok, 1);
      tick();
    end
    settle();
    check("full_count", dut.u_fifo.count, 4);
    check("full_req", bus_if.request, 0);
    check("full_d_aok", data_if.address_ok, 0);
    tick();
    bus_if.data_ok = 1'b1;
    settle();
    check("full_pop_req", bus_if.request, 0);
    check("full_pop_d_dok", data_if.data_ok, 1);
    tick();
    bus_if.data_ok = 1'b0;
    settle();
    check("resume_count", dut.u_fifo.count, 3);
    check("resume_d_aok", data_if.address_ok, 1);
    tick();
    data_if.request = 1'b0;
    settle();
    check("refull_count", dut.u_fifo.count, 4);
    bus_if.data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("drain_d_dok", data_if.data_ok, 1);
      tick();
    end
    quiet();
    settle();
    check("drain_empty", dut.u_fifo.count, 0);

    // Push and pop together at count 2.
    bus_if.address_ok = 1'b1;
    inst_if.request   = 1'b1;
    tick();
    inst_if.request = 1'b0;
    data_if.request = 1'b1;
    tick();
    data_if.request = 1'b0;
    inst_if.request = 1'b1;
    bus_if.data_ok  = 1'b1;
    settle();
    check("pp_count_before", dut.u_fifo.count, 2);
    check("pp_i_aok", inst_if.address_ok, 1);
    check("pp_i_dok", inst_if.data_ok, 1);
    check("pp_d_dok", data_if.data_ok, 0);
    tick();
    inst_if.request = 1'b0;
    settle();
    check("pp_count_after", dut.u_fifo.count, 2);
    check("pp_next_d_dok", data_if.data_ok, 1);
    tick();
    settle();
    check("pp_last_i_dok", inst_if.data_ok, 1);
    tick();
    quiet();

    // Reset with three outstanding and HOLD_DATA.
    bus_if.address_ok = 1'b1;
    inst_if.request   = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    inst_if.request   = 1'b0;
    data_if.request   = 1'b1;
    bus_if.address_ok = 1'b0;
    tick();
    settle();
    check("pre_reset_state", dut.state, ARBITER_HOLD_DATA);
    check("pre_reset_count", dut.u_fifo.count, 3);
    quiet();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    outputs_zero("midreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_request_arbiter.md
Name: memory_request_arbiter

Overview:
Shares the single SRAM-like memory port between the instruction-fetch requester and the data requester of the io stage. Each requester has its own SRAM-like channel: request, address_ok, data_ok.
- Address handshakes are granted one at a time, with data priority and a starvation guard for instruction fetch.
- An order FIFO records which requester owns each outstanding transaction, so each bus data_ok/read_data is routed back to its originator in issue order.
- Sits between the cpu_core fetch/io stages and the memory-side bridge.

Parameters:
ADDRESS_WIDTH, 32, width of every address bus
DATA_WIDTH, 32, width of read/write data
MAX_OUTSTANDING, 4, order-FIFO depth = maximum accepted-but-unanswered transactions (power of two, >= 2)
STARVE_LIMIT, 4, consecutive data grants allowed while an instruction request waits

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
inst_request  in  1  fetch wants a read
inst_address  in  ADDRESS_WIDTH  fetch address
inst_address_ok  out  1  fetch request accepted this cycle
inst_read_data  out  DATA_WIDTH  fetch read data
inst_data_ok  out  1  fetch read data valid
data_request  in  1  io stage wants a transaction
data_write  in  1  1 = store, 0 = load
data_size  in  2  0 = byte, 1 = half, 2 = word
data_write_strobe  in  4  byte enables for stores
data_address  in  ADDRESS_WIDTH  data address
data_write_data  in  DATA_WIDTH  store data
data_address_ok  out  1  data request accepted this cycle
data_read_data  out  DATA_WIDTH  load data
data_data_ok  out  1  load data or store acknowledge valid
bus_request  out  1  request to memory side
bus_write  out  1  forwarded write flag (0 for inst)
bus_size  out  2  forwarded size (2 for inst)
bus_write_strobe  out  4  forwarded strobe (0 for inst)
bus_address  out  ADDRESS_WIDTH  forwarded address
bus_write_data  out  DATA_WIDTH  forwarded store data (0 for inst)
bus_address_ok  in  1  memory side accepted the request
bus_read_data  in  DATA_WIDTH  response data
bus_data_ok  in  1  response valid, in issue order

Behaviour:
- Reset clears the FSM to IDLE, the FIFO to empty and the starve counter to 0. All outputs are 0 in the first cycle after reset.
- FSM states:
  - IDLE:
    - Chooses a source when the FIFO is not full and any request is present.
    - Data wins unless inst_request=1 and starve_count == STARVE_LIMIT; then inst wins.
    - Drives bus_* combinationally from the chosen source in the same cycle.
    - If bus_address_ok=0, moves to HOLD_INST or HOLD_DATA.
  - HOLD_INST / HOLD_DATA:
    - Source is locked; bus_* track the locked requester's inputs.
    - Requesters keep request and fields stable until address_ok (SRAM-like rule).
    - On bus_address_ok, returns to IDLE.
    - No re-arbitration while held.
- Accept rule:
  - inst_address_ok = bus_address_ok & grant==inst; data_address_ok likewise for data.
  - The ungranted source sees address_ok=0.
  - At most one accept per cycle.
- Full FIFO: bus_request=0 in IDLE. The FIFO cannot fill while in HOLD, because entry to HOLD requires not-full and the only push is the accept that leaves HOLD.
- FIFO push and pop:
  - Each accept pushes the 1-bit source (0 = inst, 1 = data).
  - Each bus_data_ok pops the head.
  - inst_data_ok = bus_data_ok & head==inst; data_data_ok = bus_data_ok & head==data.
  - Both read_data outputs = bus_read_data.
  - Latency from bus_data_ok to requester data_ok is 0 cycles (combinational).
- Simultaneous push and pop in one cycle: count unchanged, pointers both advance. A full FIFO with a same-cycle pop still does not issue; issue re-evaluates next cycle.
- Pointer width is log2(MAX_OUTSTANDING) and wraps modulo depth. Count width is log2(MAX_OUTSTANDING)+1.
- bus_data_ok with an empty FIFO is a protocol error: ignored, no pop, no requester data_ok, simulation assertion fires.
- Starve counter:
  - Increments on each data accept while inst_request=1, saturating at STARVE_LIMIT.
  - Clears on any inst accept, or on any cycle with inst_request=0.
- Reset mid-transaction discards the FSM and FIFO contents. The memory side is reset by the same signal.
- Pipeline flush is not handled here. The io stage keeps counting its own pending responses and still consumes them through data_data_ok.

Decomposition:
- Package memory_arbiter_params holds:
  - source enum source_t {SOURCE_INST, SOURCE_DATA};
  - FSM state enum arbiter_state_t {ARBITER_IDLE, ARBITER_HOLD_INST, ARBITER_HOLD_DATA};
  - size constants SIZE_BYTE/HALF/WORD.
- One sub-module, request_order_fifo (parameterised depth, 1-bit payload, full/empty/count outputs), instantiated once.

Test Plan:
- Both sources request together in IDLE, bus_address_ok=1 every cycle, starve_count=0 -> data granted first (data_address_ok=1, inst_address_ok=0). After 4 data accepts with inst waiting, the 5th grant is inst.
- Data request, bus_address_ok held 0 for 3 cycles, inst_request rises in cycle 2 -> grant stays data until accept, then inst is granted in IDLE next.
- Issue inst A, data B, inst C with no responses; return three bus_data_ok with 0x11, 0x22, 0x33 -> inst_data_ok gets 0x11, data_data_ok gets 0x22, inst_data_ok gets 0x33, in that order.
- Fill to 4 outstanding -> bus_request=0. Pop and request in the same cycle -> issue resumes the next cycle; count never exceeds 4.
- Accept and bus_data_ok in the same cycle at count=2 -> count remains 2, head routing correct.
- Assert reset with 3 outstanding and the FSM in HOLD_DATA -> next cycle all outputs 0, FIFO empty, state IDLE.
